// File: rtl/sync_up_counter_gl.sv
// rtl/sync_up_counter_gl.sv - 4-bit gate-level up counter with load, enable, decade mode and terminal count
// Flop cell plus next-state network built only from gate primitives.

module DFlipFlop (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= 1'b0;
        else
            q <= d;
    end
endmodule

module sync_up_counter_gl (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec_mode,
    output logic [3:0] out,
    output logic       tc
);
    wire [3:0] q;
    wire [3:0] inc;
    wire [3:0] cnt;
    wire [3:0] nxt;
    wire       c1, c2;
    wire       lo_any, ge9, all15;
    wire       ndec, wrap_dec, wrap_bin, wrap, nwrap;
    wire       nload, nen, sel_cnt, sel_hold;

    // Ripple-carry incrementer
    not g_inc0 (inc[0], q[0]);
    xor g_inc1 (inc[1], q[1], q[0]);
    and g_c1   (c1, q[1], q[0]);
    xor g_inc2 (inc[2], q[2], c1);
    and g_c2   (c2, q[2], c1);
    xor g_inc3 (inc[3], q[3], c2);

    // Wrap detect: decade wraps on any value >= 9 so loaded 10..15 recover to 0
    or  g_lo_any (lo_any, q[0], q[1], q[2]);
    and g_ge9    (ge9, q[3], lo_any);
    and g_all15  (all15, q[3], c2);
    not g_ndec   (ndec, dec_mode);
    and g_wdec   (wrap_dec, dec_mode, ge9);
    and g_wbin   (wrap_bin, ndec, all15);
    or  g_wrap   (wrap, wrap_dec, wrap_bin);
    not g_nwrap  (nwrap, wrap);
    and g_tc     (tc, en, wrap);

    // One-hot selection: load > count > hold
    not g_nload (nload, load);
    not g_nen   (nen, en);
    and g_scnt  (sel_cnt, nload, en);
    and g_shold (sel_hold, nload, nen);

    genvar i;
    generate
        for (i = 0; i < 4; i++) begin : g_bit
            wire t_load, t_cnt, t_hold;
            and g_cnt   (cnt[i], inc[i], nwrap);
            and g_tload (t_load, load, load_val[i]);
            and g_tcnt  (t_cnt, sel_cnt, cnt[i]);
            and g_thold (t_hold, sel_hold, q[i]);
            or  g_nxt   (nxt[i], t_load, t_cnt, t_hold);

            DFlipFlop u_ff (
                .clk (clk),
                .rst (rst),
                .d   (nxt[i]),
                .q   (q[i])
            );
        end
    endgenerate

    assign out = q;
endmodule
